// File: rtl/pir_multi_alarm.sv
// N-channel PIR motion-alarm controller: per-channel decimated window averaging,
// threshold trip detection, timed buzzer and persistent alarm statistics.
module pir_multi_alarm #(
  parameter int N_CH        = 3,
  parameter int SAMPLE_W    = 7,
  parameter int AVG_LOG2    = 2,
  parameter int SAMPLE_DIV  = 4,
  parameter int BUZZ_CYCLES = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     stop_alarm,
  input  logic                     clear_stats,
  input  logic [SAMPLE_W-1:0]      threshold,
  input  logic [N_CH*SAMPLE_W-1:0] pir_sensor,
  output logic [N_CH-1:0]          led,
  output logic                     buzzer,
  output logic [N_CH*SAMPLE_W-1:0] avg_out,
  output logic                     avg_valid,
  output logic [SAMPLE_W-1:0]      last_level,
  output logic [SAMPLE_W-1:0]      peak_level,
  output logic [7:0]               trigger_count,
  output logic [1:0]               state_out
);

  localparam int WIN    = 1 << AVG_LOG2;
  localparam int ACC_W  = SAMPLE_W + AVG_LOG2;
  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int IDX_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int BUZZ_W = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIN - 1);
  localparam logic [BUZZ_W-1:0] BUZZ_LAST = BUZZ_W'(BUZZ_CYCLES - 1);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_ARMED = 2'd1,
    S_ALARM = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    sample_idx;
  logic [BUZZ_W-1:0]   buzz_cnt;
  logic [ACC_W-1:0]    acc     [N_CH];
  logic [ACC_W-1:0]    acc_sum [N_CH];
  logic [SAMPLE_W-1:0] avg_new [N_CH];
  logic [N_CH-1:0]     trip;
  logic [SAMPLE_W-1:0] trip_max;
  logic [3:0]          trip_cnt;
  logic                strobe;
  logic                window_done;
  logic                alarm_entry;
  logic [7:0]          base_cnt;
  logic [8:0]          cnt_sum;
  logic [7:0]          cnt_next;
  logic [SAMPLE_W-1:0] base_peak;
  logic [SAMPLE_W-1:0] peak_next;

  assign strobe      = (state == S_ARMED) && enable && (div_cnt == DIV_LAST);
  assign window_done = strobe && (sample_idx == IDX_LAST);
  assign alarm_entry = (state == S_ARMED) && (state_nxt == S_ALARM);
  assign state_out   = state;

  // The window average includes the sample arriving on the closing strobe.
  always_comb begin
    trip     = '0;
    trip_max = '0;
    trip_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      acc_sum[i] = acc[i] + ACC_W'(pir_sensor[i*SAMPLE_W +: SAMPLE_W]);
      avg_new[i] = SAMPLE_W'(acc_sum[i] >> AVG_LOG2);
      if (avg_new[i] >= threshold) begin
        trip[i]  = 1'b1;
        trip_cnt = trip_cnt + 4'd1;
        if (avg_new[i] > trip_max) trip_max = avg_new[i];
      end
    end
  end

  always_comb begin
    base_cnt  = clear_stats ? 8'd0 : trigger_count;
    cnt_sum   = {1'b0, base_cnt} + 9'(trip_cnt);
    cnt_next  = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    base_peak = clear_stats ? '0 : peak_level;
    peak_next = (trip_max > base_peak) ? trip_max : base_peak;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_OFF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    buzzer    = 1'b0;
    case (state)
      S_OFF: begin
        if (enable) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (!enable)                state_nxt = S_OFF;
        else if (window_done && |trip) state_nxt = S_ALARM;
      end
      S_ALARM: begin
        buzzer = 1'b1;
        if ((buzz_cnt == BUZZ_LAST) || stop_alarm || !enable) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        state_nxt = enable ? S_ARMED : S_OFF;
      end
      default: state_nxt = S_OFF;
    endcase
  end

  // Sampling only runs while armed; every other state keeps the window empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt       <= '0;
      sample_idx    <= '0;
      buzz_cnt      <= '0;
      for (int i = 0; i < N_CH; i++) acc[i] <= '0;
      avg_out       <= '0;
      avg_valid     <= 1'b0;
      led           <= '0;
      last_level    <= '0;
      peak_level    <= '0;
      trigger_count <= '0;
    end else begin
      avg_valid <= 1'b0;
      if ((state == S_ARMED) && enable) begin
        if (strobe) begin
          div_cnt <= '0;
          if (window_done) begin
            sample_idx <= '0;
            avg_valid  <= 1'b1;
            for (int i = 0; i < N_CH; i++) begin
              acc[i] <= '0;
              avg_out[i*SAMPLE_W +: SAMPLE_W] <= avg_new[i];
            end
          end else begin
            sample_idx <= sample_idx + IDX_W'(1);
            for (int i = 0; i < N_CH; i++) acc[i] <= acc_sum[i];
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end else begin
        div_cnt    <= '0;
        sample_idx <= '0;
        for (int i = 0; i < N_CH; i++) acc[i] <= '0;
      end

      buzz_cnt <= (state == S_ALARM) ? buzz_cnt + BUZZ_W'(1) : '0;

      if (state_nxt != S_ALARM) led <= '0;
      else if (alarm_entry)     led <= trip;

      // A clear coinciding with alarm entry is folded into base_cnt/base_peak.
      if (alarm_entry) begin
        trigger_count <= cnt_next;
        last_level    <= trip_max;
        peak_level    <= peak_next;
      end else if (clear_stats) begin
        trigger_count <= '0;
        last_level    <= '0;
        peak_level    <= '0;
      end
    end
  end

endmodule

// File: doc/pir_multi_alarm.md
# pir_multi_alarm

Parametrised N-channel PIR motion-alarm controller: the next-generation replacement for the fixed three-sensor alarm FSM. It decimates and window-averages each sensor channel, compares each average against a run-time threshold, and drives per-channel LEDs and a timed buzzer. It also keeps peak/last/trigger statistics that persist across disarm. It sits between the sensor sampling front end and the display/indicator logic.

## Interface
- N_CH, 3: number of PIR channels (1..8).
- SAMPLE_W, 7: bits per sensor sample, unsigned.
- AVG_LOG2, 2: averaging window WIN = 2^AVG_LOG2 samples.
- SAMPLE_DIV, 4: clock cycles between sample strobes (≥1).
- BUZZ_CYCLES, 100: buzzer on-time in cycles (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  arm (1) / disarm (0).
- stop_alarm  in  1  user acknowledge; ends an active alarm.
- clear_stats  in  1  one-cycle pulse; zeroes statistics.
- threshold  in  SAMPLE_W  trip level; channel trips when avg ≥ threshold.
- pir_sensor  in  N_CH*SAMPLE_W  packed samples; channel i at [i*SAMPLE_W +: SAMPLE_W].
- led  out  N_CH  tripped-channel mask during alarm.
- buzzer  out  1  high while in ALARM.
- avg_out  out  N_CH*SAMPLE_W  latest window averages, same packing.
- avg_valid  out  1  one-cycle pulse when avg_out updates.
- last_level  out  SAMPLE_W  highest tripped average of the most recent alarm.
- peak_level  out  SAMPLE_W  maximum last_level since reset/clear.
- trigger_count  out  8  cumulative tripped-channel count, saturates at 255.
- state_out  out  2  OFF=0, ARMED=1, ALARM=2, CLEAR=3.

## Operation
- Reset: state OFF; every output, accumulator and counter 0.
- OFF: no sampling; led=0, buzzer=0. enable=1 → ARMED with div counter, sample index, accumulators cleared.
- ARMED: div counter counts 0..SAMPLE_DIV-1; at count SAMPLE_DIV-1 (strobe) each channel adds its sample to a (SAMPLE_W+AVG_LOG2)-bit accumulator; no overflow possible.
- On the strobe completing WIN samples: avg_i = (acc_i + sample_i) >> AVG_LOG2 (truncating) registered into avg_out, avg_valid=1 next cycle, accumulators and sample index cleared.
- Same edge: trip mask m = {avg_i ≥ threshold}. If m≠0: led<=m, state → ALARM, trigger_count += popcount(m) (saturating), last_level <= max tripped avg_i, peak_level <= max(peak_level, that value).
- ARMED with enable=0 → OFF; partial window discarded. stop_alarm ignored outside ALARM.
- ALARM: buzzer=1, led holds m, sampling frozen, buzz counter increments. Exit to CLEAR when buzz counter reaches BUZZ_CYCLES-1, or stop_alarm=1, or enable=0 (any combination, same result).
- CLEAR: one cycle; buzzer=0, led=0, counters and accumulators cleared; then ARMED if enable=1, else OFF.
- clear_stats: zeroes last_level, peak_level, trigger_count; if coincident with alarm entry, the clear applies first and the entry update is then applied (count = popcount(m)).
- avg_out and statistics persist across OFF; only rst/clear_stats clear them.

## Timing
- ARMED cycles numbered from 1: strobes at cycles k*SAMPLE_DIV; first avg_valid during cycle WIN*SAMPLE_DIV+1 (17 with defaults).
- Trip to buzzer: buzzer rises in the same cycle avg_valid is high.
- Buzzer high exactly BUZZ_CYCLES cycles without stop; minimum 1 cycle when stop_alarm is already high on entry.
- stop_alarm sampled high in ALARM cycle n → CLEAR in cycle n+1, buzzer low.
- rst mid-alarm: buzzer/led drop immediately (asynchronous); statistics cleared.

## Test plan
- Defaults, threshold=50, all sensors 10, enable=1 → avg_valid every 16 cycles from cycle 17, avg_out all 10, buzzer never rises, state_out stays 1.
- Channel 1 held at 60, others 10 → cycle 17: led=3'b010, buzzer=1 for 100 cycles, trigger_count=1, last_level=60, peak_level=60, then CLEAR, re-arm.
- Channels 0 and 2 = 80/55 → led=3'b101, trigger_count+=2, last_level=80; stop_alarm pulse at ALARM cycle 5 → buzzer low next cycle.
- Window average truncation: channel 0 samples 49,50,51,51 (sum 201) → avg 50, trips at threshold 50; sum 199 → avg 49, no trip.
- enable dropped mid-window and mid-alarm → state OFF via CLEAR, led/buzzer 0, statistics retained; clear_stats → last/peak/count 0.
- Saturation: 100 alarms with N_CH=3 all tripping → trigger_count 255, no wrap; rst asserted mid-ALARM → all outputs 0 asynchronously.
